// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Op codes and helper functions for the pipelined systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOR = 2'd3;

    function automatic logic sys_op(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Sample reaches cell (ROW,COLUMN) after ROW+COLUMN-1 advancing edges.
    function automatic int sys_latency(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_cell.sv
// ============================================================================
// Module      : systolic_cell
// Description : One registered array cell: q <= op(h, v) when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_cell
    import systolic_pkg::*;
#(
    parameter logic [1:0] OP = OP_AND
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic h,
    input  logic v,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= sys_op(OP, h, v);
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_pipe.sv
// ============================================================================
// Module      : systolic_pipe
// Description : Pipelined ROW x COLUMN systolic gate array with valid/ready
//               handshakes; one sample accepted per cycle, one bit out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pipe
    import systolic_pkg::*;
#(
    parameter int         ROW      = 4,
    parameter int         COLUMN   = 12,
    parameter logic [1:0] OP_DIAG  = OP_AND,
    parameter logic [1:0] OP_UPPER = OP_XOR,
    parameter logic [1:0] OP_LOWER = OP_OR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW-1:0]    inRow,
    input  logic [COLUMN-1:0] inColumn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out
);

    localparam int L = sys_latency(ROW, COLUMN);

    logic                          w_adv;
    logic                          w_accept;
    logic [ROW-1:0]                w_row_sk;
    logic [COLUMN-1:0]             w_col_sk;
    logic [ROW-1:0][COLUMN-1:0]    w_q;
    logic [L-1:0]                  r_valid;

    // The whole array moves in lockstep; a stalled output freezes everything.
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign w_accept  = in_valid && w_adv;
    assign out_valid = r_valid[L-1];
    assign out       = w_q[ROW-1][COLUMN-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid[0] <= w_accept;
            for (int k = 1; k < L; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row_skew
        if (r == 0) begin : g_direct
            assign w_row_sk[r] = inRow[r];
        end else begin : g_delay
            logic [r-1:0] r_sk;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sk <= '0;
                end else if (w_adv) begin
                    r_sk[0] <= inRow[r];
                    for (int k = 1; k < r; k++) begin
                        r_sk[k] <= r_sk[k-1];
                    end
                end
            end
            assign w_row_sk[r] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < COLUMN; c++) begin : g_col_skew
        if (c == 0) begin : g_direct
            assign w_col_sk[c] = inColumn[c];
        end else begin : g_delay
            logic [c-1:0] r_sk;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sk <= '0;
                end else if (w_adv) begin
                    r_sk[0] <= inColumn[c];
                    for (int k = 1; k < c; k++) begin
                        r_sk[k] <= r_sk[k-1];
                    end
                end
            end
            assign w_col_sk[c] = r_sk[c-1];
        end
    end

    for (genvar i = 0; i < ROW; i++) begin : g_cell_row
        for (genvar j = 0; j < COLUMN; j++) begin : g_cell_col
            localparam logic [1:0] CELL_OP = (i == j) ? OP_DIAG :
                                             (i <  j) ? OP_UPPER : OP_LOWER;
            logic w_h;
            logic w_v;

            if (j == 0) begin : g_h_edge
                assign w_h = w_row_sk[i];
            end else begin : g_h_int
                assign w_h = w_q[i][j-1];
            end

            if (i == 0) begin : g_v_edge
                assign w_v = w_col_sk[j];
            end else begin : g_v_int
                assign w_v = w_q[i-1][j];
            end

            systolic_cell #(
                .OP (CELL_OP)
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .en  (w_adv),
                .h   (w_h),
                .v   (w_v),
                .q   (w_q[i][j])
            );
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_pipe.sv
// ============================================================================
// Module      : tb_systolic_pipe
// Description : Scoreboard bench for systolic_pipe (default + three re-sized DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, out;
    logic [3:0]  inRow;
    logic [11:0] inColumn;

    systolic_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inRow(inRow), .inColumn(inColumn), .out_valid(out_valid),
        .out_ready(out_ready), .out(out)
    );

    logic       a_iv, a_ir, a_ov, a_or, a_o;
    logic [1:0] a_r;
    logic [2:0] a_c;
    systolic_pipe #(.ROW(2), .COLUMN(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .inRow(a_r),
        .inColumn(a_c), .out_valid(a_ov), .out_ready(a_or), .out(a_o)
    );

    logic       b_iv, b_ir, b_ov, b_or, b_o;
    logic [5:0] b_r, b_c;
    systolic_pipe #(.ROW(6), .COLUMN(6), .OP_DIAG(2'd3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .inRow(b_r),
        .inColumn(b_c), .out_valid(b_ov), .out_ready(b_or), .out(b_o)
    );

    logic       c_iv, c_ir, c_ov, c_or, c_o;
    logic [0:0] c_r;
    logic [4:0] c_c;
    systolic_pipe #(.ROW(1), .COLUMN(5)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .inRow(c_r),
        .inColumn(c_c), .out_valid(c_ov), .out_ready(c_or), .out(c_o)
    );

    int   checks = 0;
    int   passes = 0;
    logic exp_q[$];
    logic got_out, last_exp, last_out, s_in_ready, s_out_valid, s_out, acc;

    // Golden combinational array, ops 0=AND 1=OR 2=XOR 3=NOR.
    function automatic logic model(input int R, input int C, input logic [1:0] od,
                                   input logic [1:0] ou, input logic [1:0] ol,
                                   input logic [11:0] rb, input logic [11:0] cb);
        logic       g [0:5][0:11];
        logic       h, v, res;
        logic [1:0] op;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
                h  = (j == 0) ? rb[i] : g[i][j-1];
                v  = (i == 0) ? cb[j] : g[i-1][j];
                op = (i == j) ? od : ((i < j) ? ou : ol);
                case (op)
                    2'd0:    res = h & v;
                    2'd1:    res = h | v;
                    2'd2:    res = h ^ v;
                    default: res = ~(h | v);
                endcase
                g[i][j] = res;
            end
        end
        return g[R-1][C-1];
    endfunction

    // One cycle on the default DUT: drive, sample at negedge, update scoreboard.
    task automatic step(input logic v, input logic [3:0] r, input logic [11:0] c,
                        input logic ordy);
        in_valid  = v;
        inRow     = r;
        inColumn  = c;
        out_ready = ordy;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out       = out;
        acc         = v && in_ready;
        if (acc) exp_q.push_back(model(4, 12, 2'd0, 2'd2, 2'd1, {8'd0, r}, c));
        got_out  = out_valid && ordy;
        last_out = out;
        if (got_out) begin
            if (exp_q.size() > 0) last_exp = exp_q.pop_front();
            else                  last_exp = 1'bx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; inRow = '0; inColumn = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passes++;
        checks++;
        if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        exp_q.delete();
        for (int k = 0; k <= 15; k++) begin
            step(k == 0, 4'h0, 12'h800, 1'b1);
            if (k == 0) begin
                checks++;
                if (s_in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", s_in_ready);
                else passes++;
            end
            if (k < 15) begin
                checks++;
                if (s_out_valid !== 1'b0) $display("FAIL single_early_valid k=%0d: got %b want 0", k, s_out_valid);
                else passes++;
            end else begin
                checks++;
                if (s_out_valid !== 1'b1) $display("FAIL single_latency: got %b want 1", s_out_valid);
                else passes++;
                checks++;
                if (s_out !== 1'b1) $display("FAIL single_out: got %b want 1", s_out);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  rr [0:3];
        logic [11:0] cc [0:3];
        logic [3:0]  req;
        logic        ev;
        rr[0] = 4'h1; cc[0] = 12'h001;
        rr[1] = 4'h0; cc[1] = 12'h001;
        rr[2] = 4'h0; cc[2] = 12'h000;
        rr[3] = 4'h0; cc[3] = 12'h800;
        req = 4'b1001;
        for (int k = 0; k < 20; k++) begin
            step(k < 4, (k < 4) ? rr[k % 4] : 4'h0, (k < 4) ? cc[k % 4] : 12'h0, 1'b1);
            ev = (k >= 15 && k < 19);
            checks++;
            if (s_out_valid !== ev) $display("FAIL b2b_valid k=%0d: got %b want %b", k, s_out_valid, ev);
            else passes++;
            if (ev) begin
                checks++;
                if (s_out !== req[k-15]) $display("FAIL b2b_out k=%0d: got %b want %b", k, s_out, req[k-15]);
                else passes++;
                checks++;
                if (last_out !== last_exp) $display("FAIL b2b_scoreboard k=%0d: got %b want %b", k, last_out, last_exp);
                else passes++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0]  rr [0:39];
        logic [11:0] cc [0:39];
        int          n, outs;
        logic        stall, held;
        n = 0; outs = 0; held = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rr[i] = 4'($urandom);
            cc[i] = 12'($urandom);
        end
        for (int k = 0; k < 200 && !(n == 40 && outs == 40); k++) begin
            stall = (k >= 20 && k < 25);
            step(n < 40, (n < 40) ? rr[n] : 4'h0, (n < 40) ? cc[n] : 12'h0, !stall);
            if (k == 20) held = s_out;
            if (stall) begin
                checks++;
                if (s_in_ready !== 1'b0) $display("FAIL bp_in_ready k=%0d: got %b want 0", k, s_in_ready);
                else passes++;
                checks++;
                if (s_out_valid !== 1'b1) $display("FAIL bp_valid_held k=%0d: got %b want 1", k, s_out_valid);
                else passes++;
                checks++;
                if (s_out !== held) $display("FAIL bp_out_stable k=%0d: got %b want %b", k, s_out, held);
                else passes++;
            end
            if (acc) n++;
            if (got_out) begin
                outs++;
                checks++;
                if (last_out !== last_exp) $display("FAIL bp_result #%0d: got %b want %b", outs, last_out, last_exp);
                else passes++;
            end
        end
        checks++;
        if (outs != 40) $display("FAIL bp_count: got %0d results want 40", outs);
        else passes++;
    endtask

    task automatic test_bubbles;
        logic pat [0:19];
        logic ev;
        for (int k = 0; k < 20; k++) pat[k] = (k % 2 == 0);
        for (int k = 0; k < 36; k++) begin
            step((k < 20) ? pat[k] : 1'b0, 4'($urandom), 12'($urandom), 1'b1);
            ev = (k >= 15 && k < 35) ? pat[k-15] : 1'b0;
            checks++;
            if (s_out_valid !== ev) $display("FAIL bubble_valid k=%0d: got %b want %b", k, s_out_valid, ev);
            else passes++;
            if (got_out) begin
                checks++;
                if (last_out !== last_exp) $display("FAIL bubble_out k=%0d: got %b want %b", k, last_out, last_exp);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        for (int k = 0; k < 10; k++) step(1'b1, 4'($urandom), 12'($urandom), 1'b1);
        rst = 1'b1;
        step(1'b0, 4'h0, 12'h0, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k <= 15; k++) begin
            step(k == 0, 4'($urandom), 12'($urandom), 1'b1);
            if (k == 0) begin
                checks++;
                if (s_in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", s_in_ready);
                else passes++;
            end
            if (k < 15) begin
                checks++;
                if (s_out_valid !== 1'b0) $display("FAIL rstmid_valid k=%0d: got %b want 0", k, s_out_valid);
                else passes++;
            end else begin
                checks++;
                if (s_out_valid !== 1'b1) $display("FAIL rstmid_latency: got %b want 1", s_out_valid);
                else passes++;
                checks++;
                if (last_out !== last_exp) $display("FAIL rstmid_out: got %b want %b", last_out, last_exp);
                else passes++;
            end
        end
    endtask

    task automatic test_sweep;
        logic ha_v [0:219], ha_e [0:219];
        logic hb_v [0:219], hb_e [0:219];
        logic hc_v [0:219], hc_e [0:219];
        logic ev;
        for (int k = 0; k < 215; k++) begin
            a_iv = (k < 200); a_r = 2'($urandom); a_c = 3'($urandom);
            b_iv = (k < 200); b_r = 6'($urandom); b_c = 6'($urandom);
            c_iv = (k < 200); c_r = 1'($urandom); c_c = 5'($urandom);
            @(negedge clk);
            ha_v[k] = a_iv; ha_e[k] = model(2, 3, 2'd0, 2'd2, 2'd1, 12'(a_r), 12'(a_c));
            hb_v[k] = b_iv; hb_e[k] = model(6, 6, 2'd3, 2'd2, 2'd1, 12'(b_r), 12'(b_c));
            hc_v[k] = c_iv; hc_e[k] = model(1, 5, 2'd0, 2'd2, 2'd1, 12'(c_r), 12'(c_c));

            checks++;
            if ((a_ir & b_ir & c_ir) !== 1'b1) $display("FAIL sweep_in_ready k=%0d: got %b%b%b want 111", k, a_ir, b_ir, c_ir);
            else passes++;

            ev = (k >= 4) ? ha_v[k-4] : 1'b0;
            checks++;
            if (a_ov !== ev) $display("FAIL sweepA_valid k=%0d: got %b want %b", k, a_ov, ev);
            else passes++;
            if (ev) begin
                checks++;
                if (a_o !== ha_e[k-4]) $display("FAIL sweepA_out k=%0d: got %b want %b", k, a_o, ha_e[k-4]);
                else passes++;
            end

            ev = (k >= 11) ? hb_v[k-11] : 1'b0;
            checks++;
            if (b_ov !== ev) $display("FAIL sweepB_valid k=%0d: got %b want %b", k, b_ov, ev);
            else passes++;
            if (ev) begin
                checks++;
                if (b_o !== hb_e[k-11]) $display("FAIL sweepB_out k=%0d: got %b want %b", k, b_o, hb_e[k-11]);
                else passes++;
            end

            ev = (k >= 5) ? hc_v[k-5] : 1'b0;
            checks++;
            if (c_ov !== ev) $display("FAIL sweepC_valid k=%0d: got %b want %b", k, c_ov, ev);
            else passes++;
            if (ev) begin
                checks++;
                if (c_o !== hc_e[k-5]) $display("FAIL sweepC_out k=%0d: got %b want %b", k, c_o, hc_e[k-5]);
                else passes++;
            end
            @(posedge clk);
            #1;
        end
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    endtask

    initial begin
        a_iv = 1'b0; a_or = 1'b1; a_r = '0; a_c = '0;
        b_iv = 1'b0; b_or = 1'b1; b_r = '0; b_c = '0;
        c_iv = 1'b0; c_or = 1'b1; c_r = '0; c_c = '0;
        last_exp = 1'b0; last_out = 1'b0; got_out = 1'b0; acc = 1'b0;
        s_in_ready = 1'b0; s_out_valid = 1'b0; s_out = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
